// File: rtl/eq_compute_seq.sv
// rtl/eq_compute_seq.sv - multi-cycle add/sub/shift-add multiply/restoring divide engine
//
// Purpose: computes num1 <op> num2 over several clock cycles for the equation
// display path. The operands and the operator are latched when the engine accepts
// a request. Results appear on the outputs only in the single FIN cycle.
// Optional feature macro: EQ_COMPUTE_BCD_OUT_EN. It adds a double-dabble BCD
// stage and the bcd port.
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start            request, taken when idle or in the FIN cycle
//   num1, num2, op   operands and operator (0 +, 1 -, 2 *, 3 /, 4 %, other illegal)
//   busy, done       operation in progress / one-cycle completion pulse
//   result           unsigned magnitude of the result
//   neg, div0, err   negative difference / divide by zero / illegal op
//   bcd              packed BCD of result, digit 0 in [3:0] (BCD build only)
module eq_compute_seq #(
    parameter int W      = 10,
    parameter int RES_W  = 2 * W,
    parameter int DIGITS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     num1,
    input  logic [W-1:0]     num2,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             neg,
    output logic             div0,
`ifdef EQ_COMPUTE_BCD_OUT_EN
    output logic             err,
    output logic [4*DIGITS-1:0] bcd
`else
    output logic             err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
`ifdef EQ_COMPUTE_BCD_OUT_EN
    localparam logic [1:0] S_BCD  = 2'd2;
`endif
    localparam logic [1:0] S_FIN  = 2'd3;
    localparam int CW = $clog2(RES_W + 1);

    logic [1:0]       state_q, state_d;
    logic [W-1:0]     a_q, a_d;           // dividend, which becomes the quotient
    logic [W-1:0]     b_q, b_d;           // divisor, or the multiplier shifted right
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RES_W-1:0] acc_q, acc_d;       // product accumulator
    logic [RES_W-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
    logic [W-1:0]     rem_q, rem_d;       // partial remainder
    logic [RES_W-1:0] result_q, result_d;
    logic             neg_q, neg_d, div0_q, div0_d, err_q, err_d;

`ifdef EQ_COMPUTE_BCD_OUT_EN
    logic [RES_W-1:0]    val_q, val_d;    // finished binary result, held through BCD
    logic [RES_W-1:0]    sr_q, sr_d;      // binary bits still to shift into BCD
    logic [4*DIGITS-1:0] bw_q, bw_d;      // BCD digits under construction
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                pneg_q, pneg_d, pdiv0_q, pdiv0_d, perr_q, perr_d;
    logic [4*DIGITS-1:0] corr;
    logic [4*DIGITS-1:0] bw_n;
`endif

    // One iteration of each multi-cycle algorithm, evaluated from the current state.
    logic [RES_W-1:0] mul_acc_n;
    logic [W:0]       rem_sh;
    logic             rem_ge;
    logic [W-1:0]     rem_n;
    logic [W-1:0]     quo_n;
    logic [W:0]       sum;
    logic             last_iter;

    logic             c_fin, c_neg, c_div0, c_err;
    logic [RES_W-1:0] c_val;

    always_comb begin
        mul_acc_n = acc_q + (b_q[0] ? mcand_q : '0);
        rem_sh    = {rem_q, a_q[W-1]};
        rem_ge    = (rem_sh >= {1'b0, b_q});
        rem_n     = rem_ge ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
        quo_n     = {a_q[W-2:0], rem_ge};
        sum       = {1'b0, a_q} + {1'b0, b_q};
        last_iter = (cnt_q == CW'(W - 1));
    end

    // Finishing value of the CALC state. c_fin marks the last CALC cycle.
    always_comb begin
        c_fin  = 1'b1;
        c_val  = '0;
        c_neg  = 1'b0;
        c_div0 = 1'b0;
        c_err  = 1'b0;
        case (op_q)
            3'd0: c_val = RES_W'(sum);
            3'd1: begin
                if (a_q >= b_q) begin
                    c_val = RES_W'(a_q - b_q);
                end else begin
                    c_val = RES_W'(b_q - a_q);
                    c_neg = 1'b1;
                end
            end
            3'd2: begin
                c_fin = last_iter;
                c_val = mul_acc_n;
            end
            3'd3, 3'd4: begin
                if (b_q == '0) begin
                    c_div0 = 1'b1;
                end else begin
                    c_fin = last_iter;
                    c_val = (op_q == 3'd3) ? RES_W'(quo_n) : RES_W'(rem_n);
                end
            end
            default: c_err = 1'b1;
        endcase
    end

`ifdef EQ_COMPUTE_BCD_OUT_EN
    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    always_comb begin
        corr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            corr[4*i +: 4] = (bw_q[4*i +: 4] >= 4'd5) ? bw_q[4*i +: 4] + 4'd3
                                                      : bw_q[4*i +: 4];
        end
        bw_n = {corr[4*DIGITS-2:0], sr_q[RES_W-1]};
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        result_d = result_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        err_d    = err_q;
`ifdef EQ_COMPUTE_BCD_OUT_EN
        val_d    = val_q;
        sr_d     = sr_q;
        bw_d     = bw_q;
        bcd_d    = bcd_q;
        pneg_d   = pneg_q;
        pdiv0_d  = pdiv0_q;
        perr_d   = perr_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                // The FIN cycle also accepts a request, so operations run back to back.
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_CALC;
                    a_d     = num1;
                    b_d     = num2;
                    op_d    = op;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = RES_W'(num1);
                    rem_d   = '0;
                    neg_d   = 1'b0;
                    div0_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CALC: begin
                cnt_d   = cnt_q + CW'(1);
                acc_d   = mul_acc_n;
                mcand_d = mcand_q << 1;
                if (op_q == 3'd2) begin
                    b_d = b_q >> 1;
                end
                if (op_q == 3'd3 || op_q == 3'd4) begin
                    a_d   = quo_n;
                    rem_d = rem_n;
                end
                if (c_fin) begin
`ifdef EQ_COMPUTE_BCD_OUT_EN
                    state_d = S_BCD;
                    cnt_d   = '0;
                    val_d   = c_val;
                    sr_d    = c_val;
                    bw_d    = '0;
                    pneg_d  = c_neg;
                    pdiv0_d = c_div0;
                    perr_d  = c_err;
`else
                    state_d  = S_FIN;
                    result_d = c_val;
                    neg_d    = c_neg;
                    div0_d   = c_div0;
                    err_d    = c_err;
`endif
                end
            end
`ifdef EQ_COMPUTE_BCD_OUT_EN
            S_BCD: begin
                cnt_d = cnt_q + CW'(1);
                bw_d  = bw_n;
                sr_d  = sr_q << 1;
                if (cnt_q == CW'(RES_W - 1)) begin
                    state_d  = S_FIN;
                    result_d = val_q;
                    bcd_d    = bw_n;
                    neg_d    = pneg_q;
                    div0_d   = pdiv0_q;
                    err_d    = perr_q;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef EQ_COMPUTE_BCD_OUT_EN
            val_q    <= '0;
            sr_q     <= '0;
            bw_q     <= '0;
            bcd_q    <= '0;
            pneg_q   <= 1'b0;
            pdiv0_q  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            err_q    <= err_d;
`ifdef EQ_COMPUTE_BCD_OUT_EN
            val_q    <= val_d;
            sr_q     <= sr_d;
            bw_q     <= bw_d;
            bcd_q    <= bcd_d;
            pneg_q   <= pneg_d;
            pdiv0_q  <= pdiv0_d;
            perr_q   <= perr_d;
`endif
        end
    end

`ifdef EQ_COMPUTE_BCD_OUT_EN
    assign busy = (state_q == S_CALC) || (state_q == S_BCD);
    assign bcd  = bcd_q;
`else
    assign busy = (state_q == S_CALC);
`endif
    assign done   = (state_q == S_FIN);
    assign result = result_q;
    assign neg    = neg_q;
    assign div0   = div0_q;
    assign err    = err_q;

endmodule

// File: tb/tb_eq_compute_seq.sv
// tb/tb_eq_compute_seq.sv - scoreboard testbench for eq_compute_seq
module tb_eq_compute_seq;

    localparam int W      = 10;
    localparam int RES_W  = 20;
    localparam int DIGITS = 7;
`ifdef EQ_COMPUTE_BCD_OUT_EN
    localparam int LB = RES_W;
`else
    localparam int LB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     num1 = '0;
    logic [W-1:0]     num2 = '0;
    logic [2:0]       op = '0;
    logic             busy, done, neg, div0, err;
    logic [RES_W-1:0] result;
`ifdef EQ_COMPUTE_BCD_OUT_EN
    logic [4*DIGITS-1:0] bcd;
`endif

    eq_compute_seq #(.W(W), .RES_W(RES_W), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .num1   (num1),
        .num2   (num2),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .neg    (neg),
        .div0   (div0),
`ifdef EQ_COMPUTE_BCD_OUT_EN
        .err    (err),
        .bcd    (bcd)
`else
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RES_W-1:0]    res;
        logic                neg;
        logic                div0;
        logic                err;
        logic [4*DIGITS-1:0] bcd;
        int                  cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [RES_W-1:0] v);
        logic [4*DIGITS-1:0] o;
        int x;
        o = '0;
        x = int'(v);
        for (int i = 0; i < DIGITS; i++) begin
            o[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return o;
    endfunction

    // Completion monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("neg", 64'(neg), 64'(e.neg));
                check("div0", 64'(div0), 64'(e.div0));
                check("err", 64'(err), 64'(e.err));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_in_fin", 64'(busy), 0);
`ifdef EQ_COMPUTE_BCD_OUT_EN
                check("bcd", 64'(bcd), 64'(e.bcd));
`endif
            end
        end
    end

    // Issue one request (called at a negedge); hold>0 keeps start high and
    // scrambles the inputs for that many cycles after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] o, input int hold);
        exp_t e;
        int   t;
        int   lc;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("idle_timeout", 1, 0);
        e.res = '0; e.neg = 1'b0; e.div0 = 1'b0; e.err = 1'b0;
        lc = 1;
        case (o)
            3'd0: e.res = RES_W'(int'(a) + int'(b));
            3'd1: if (a >= b) e.res = RES_W'(a - b);
                  else begin e.res = RES_W'(b - a); e.neg = 1'b1; end
            3'd2: begin e.res = RES_W'(int'(a) * int'(b)); lc = W; end
            3'd3: if (b == 0) e.div0 = 1'b1; else begin e.res = RES_W'(a / b); lc = W; end
            3'd4: if (b == 0) e.div0 = 1'b1; else begin e.res = RES_W'(a % b); lc = W; end
            default: e.err = 1'b1;
        endcase
        e.bcd = to_bcd(e.res);
        num1  = a;
        num2  = b;
        op    = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc + lc + LB;
        sb.push_back(e);
        for (int i = 0; i < hold; i++) begin
            num1 = W'($urandom);
            num2 = W'($urandom);
            op   = 3'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_result", 64'(result), 0);
        check("rst_flags", 64'({neg, div0, err}), 0);
`ifdef EQ_COMPUTE_BCD_OUT_EN
        check("rst_bcd", 64'(bcd), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_op(10'd54, 10'd36, 3'd4, 0);
        run_op(10'd36, 10'd54, 3'd1, 0);
        run_op(10'd54, 10'd36, 3'd0, 0);
        run_op(10'd1023, 10'd1023, 3'd2, 0);
        run_op(10'd54, 10'd36, 3'd2, 0);
        run_op(10'd54, 10'd0, 3'd3, 0);
        run_op(10'd54, 10'd36, 3'd6, 0);
        run_op(10'd54, 10'd36, 3'd3, 0);
        run_op(10'd1023, 10'd1, 3'd3, 0);
        run_op(10'd0, 10'd7, 3'd1, 0);
        run_op(10'd1000, 10'd999, 3'd2, 5);
        for (int k = 0; k < 8; k++) begin
            run_op(W'($urandom), W'($urandom_range(0, 40)), 3'($urandom_range(0, 7)), 0);
        end

        // Reset in the middle of a divide: the operation is abandoned without done.
        run_op(10'd54, 10'd36, 3'd3, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_result", 64'(result), 0);
        check("abort_flags", 64'({neg, div0, err}), 0);
`ifdef EQ_COMPUTE_BCD_OUT_EN
        check("abort_bcd", 64'(bcd), 0);
`endif
        repeat (40) @(negedge clk);
        run_op(10'd54, 10'd36, 3'd4, 0);
        run_op(10'd999, 10'd3, 3'd2, 0);

        for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
        check("drain_timeout", 64'(sb.size()), 0);
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_compute_seq.md
Name: eq_compute_seq

Overview:
- Multi-cycle arithmetic engine for the equation game.
- Takes two unsigned operands and an operator code, and computes the result with iterative shift-add multiply and restoring divide.
- Optionally converts the result to packed BCD digits for the display path.
- Sits between the operand/operator source and equation_display, clocked by the pixel-PLL clock, so the equation result is computed in hardware rather than hard-coded.

Parameters:
- W, 10: operand width in bits.
- RES_W, 2*W: result width in bits; must satisfy RES_W >= 2*W.
- DIGITS, 7: number of BCD digits output; must satisfy 10^DIGITS > 2^RES_W - 1.

Ports:
- clk, input, 1: system clock (PLL output).
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: request; sampled only when busy=0.
- num1, input, W: left operand.
- num2, input, W: right operand.
- op, input, 3: operator code. 0 +, 1 -, 2 *, 3 /, 4 %, 5..7 illegal.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle completion pulse.
- result, output, RES_W: unsigned magnitude of the result.
- neg, output, 1: result is negative (subtraction only).
- div0, output, 1: divide or modulo by zero.
- err, output, 1: illegal op code.
- bcd, output, 4*DIGITS: packed BCD of result, digit 0 in bits [3:0]; present only with BCD_OUT_EN.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous and active-low: rst_n=0 sampled on an edge forces state IDLE.
  - Reset values: busy=0, done=0, result=0, neg=0, div0=0, err=0, bcd=0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- Acceptance:
  - start is accepted on an edge where state=IDLE and start=1.
  - On acceptance, num1, num2 and op are latched into internal registers, and neg/div0/err are cleared.
  - From the next cycle, busy=1. Inputs may change freely after acceptance.
  - start while busy=1 is ignored (not queued).
- States: IDLE -> CALC -> (BCD) -> FIN -> IDLE.
  - FIN lasts one cycle. In FIN, done=1 and busy=0.
  - A start in the FIN cycle is accepted: back-to-back operation.
- CALC latency (Lc):
  - Add: 1 cycle. result = num1 + num2, zero-extended.
  - Subtract: 1 cycle. If num1 >= num2, result = num1 - num2 and neg=0. Otherwise result = num2 - num1 and neg=1.
  - Multiply: W cycles. Shift-add, one multiplier bit per cycle, LSB first. Full 2W-bit product; no overflow is possible.
  - Divide: W cycles. Restoring divider, one quotient bit per cycle. result = quotient.
  - Modulo: same path as divide; result = remainder.
  - Divide or modulo with num2=0: 1 cycle. result=0, div0=1.
  - Illegal op: 1 cycle. result=0, err=1.
- BCD state (BCD_OUT_EN only): double-dabble over RES_W cycles, one shift per cycle with add-3 correction on every digit >= 5 before each shift.
- Total latency, from accepting edge to the edge where done=1: L = Lc + Lb + 1, where Lb = RES_W with BCD_OUT_EN and 0 without.
  - Example, defaults without BCD: add = 2 cycles, mul = 11 cycles.
- Output stability:
  - result, neg, div0, err and bcd update only in the FIN cycle.
  - They then hold until the next acceptance; neg/div0/err clear at acceptance.
  - Intermediate values never appear on these outputs.
- done is never asserted for two consecutive cycles, except back-to-back operations whose second operation has L=1. That cannot occur, since L >= 2.

Optional Feature:
- Macro: EQ_COMPUTE_BCD_OUT_EN.
- Defined:
  - The BCD state and bcd port exist.
  - Latency includes RES_W extra cycles.
  - bcd equals the decimal digits of result, zero-padded to DIGITS.
- Undefined:
  - No BCD logic and no bcd port.
  - The FSM goes CALC -> FIN directly.

Test Plan:
- Modulo: num1=54, num2=36, op=4, start for one cycle -> busy for 10 cycles; done on the 11th edge.
  - result=18, neg=0, div0=0. With BCD: done at edge 31, bcd=0x0000018.
- Subtract: num1=36, num2=54, op=1 -> done at edge 2; result=18, neg=1.
  - Follow immediately with 54+36, start asserted in the done cycle -> second done 2 cycles later, result=90, neg=0.
- Multiply worst case: num1=1023, num2=1023, op=2 -> result=1046529 after 11 cycles.
  - With BCD: bcd=0x1046529.
  - Also 54*36 -> 1944.
- Divide by zero and illegal op: 54/0, op=3 -> done at edge 2, result=0, div0=1.
  - Then op=6 -> err=1, div0=0.
  - Then 54/36 -> result=1, flags clear.
- Robustness:
  - start held high during a multiply, with operands changed mid-operation -> no re-trigger, result still from the latched operands.
  - rst_n=0 for one edge at cycle 5 of a divide -> next edge busy=0 and all outputs 0; no done pulse.
  - New start after reset completes normally.
